// File: rtl/payload_reader.sv
// -----------------------------------------------------------------------------
// payload_reader
//
// Avalon-MM read master that drains a programmed run of 16-bit words from the
// 8192 x 16 single-port payload buffer. The words come out on a valid/ready
// stream. A small FIFO absorbs the buffer's fixed one-cycle read latency and
// any downstream backpressure.
//
// Build option:
//   PAYLOAD_READER_BYTESWAP_EN - when defined, each stream word is byte-swapped
//                                ({head[7:0], head[15:8]}) to network order.
//                                It changes nothing else, including timing.
//
// Ports:
//   clk, reset          system clock; asynchronous active-high reset
//   start               one-cycle run request (only honoured while idle)
//   start_addr          first buffer word address of the run
//   word_count          words to read; 0 = no-op, values above 8192 clamp
//   busy / done         run in progress / one-cycle end-of-run pulse
//   m_address           buffer word address
//   m_chipselect        buffer read strobe
//   m_write             tied low
//   m_byteenable        tied to 2'b11
//   m_clken             tied high
//   m_readdata          buffer data, valid one cycle after m_chipselect
//   out_data            stream word (FIFO head)
//   out_valid           stream valid
//   out_ready           stream ready
//   out_last            marks the final word of the run
// -----------------------------------------------------------------------------
module payload_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [1:0]        m_byteenable,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_W     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   ONE_C     = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;

  // Output FIFO: data plus a last-word tag per entry.
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
  logic              last_mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q;

  logic [ADDR_W:0]   clamped_count;
  logic [CW-1:0]     outstanding;
  logic              fifo_valid;
  logic              push;
  logic              pop;
  logic              issue;
  logic [DATA_W-1:0] fifo_head;

  assign clamped_count = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;

  assign fifo_valid  = (count_q != '0);
  assign pop         = fifo_valid & out_ready;
  assign push        = inflight_q;
  // Entries already committed to the FIFO: stored words plus the read in
  // flight. A pop in the same cycle earns no credit.
  assign outstanding = count_q + {{(CW-1){1'b0}}, inflight_q};
  assign issue       = (state_q == S_READ) && (remaining_q != '0) &&
                       (outstanding < DEPTH_C);

  // ---------------------------------------------------------------------------
  // FSM next state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = inflight_last_q;

    if (issue) begin
      inflight_last_d = (remaining_q == ONE_W);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = start_addr;
          remaining_d = clamped_count;
          state_d     = (clamped_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (issue) begin
          addr_d      = addr_q + 1'b1;  // wraps modulo buffer size
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == ONE_W) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Leave as the last word is handed over, so done follows the final
        // handshake by exactly one cycle.
        if (!inflight_q && ((count_q == '0) || ((count_q == ONE_C) && pop))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count_q covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wptr_q] <= m_readdata;
      last_mem_q[wptr_q] <= inflight_last_q;
    end
  end

  assign fifo_head = data_mem_q[rptr_q];

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy         = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign m_address    = addr_q;
  assign m_chipselect = issue;
  assign m_write      = 1'b0;
  assign m_byteenable = 2'b11;
  assign m_clken      = 1'b1;

  assign out_valid    = fifo_valid;
  assign out_last     = fifo_valid & last_mem_q[rptr_q];

  // Data is forced to zero while the FIFO is empty so an idle or reset
  // stream shows a clean zero instead of stale entries.
`ifdef PAYLOAD_READER_BYTESWAP_EN
  assign out_data = fifo_valid ? {fifo_head[7:0], fifo_head[15:8]} : '0;
`else
  assign out_data = fifo_valid ? fifo_head : '0;
`endif

endmodule

// File: tb/tb_payload_reader.sv
// -----------------------------------------------------------------------------
// tb_payload_reader
//
// Self-checking bench for payload_reader. A behavioural buffer model answers
// reads one cycle after m_chipselect. Expected stream contents and buffer
// address sequences come from the run parameters alone: the clamped count of
// consecutive addresses, modulo 8192. A scoreboard compares every handshake,
// every issued address, FIFO occupancy and backpressure stability.
// -----------------------------------------------------------------------------
module tb_payload_reader;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int NWORDS = 8192;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   word_count;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_write;
  logic [1:0]        m_byteenable;
  logic              m_clken;
  logic [DATA_W-1:0] m_readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  always #5 clk = ~clk;

  payload_reader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_addr  (start_addr),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
    .m_address   (m_address),
    .m_chipselect(m_chipselect),
    .m_write     (m_write),
    .m_byteenable(m_byteenable),
    .m_clken     (m_clken),
    .m_readdata  (m_readdata),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last)
  );

  // Buffer model: data valid exactly one cycle after the read strobe,
  // garbage otherwise so a mistimed capture shows up.
  logic [DATA_W-1:0] mem [NWORDS];
  always @(posedge clk) begin
    if (m_chipselect) m_readdata <= mem[m_address];
    else              m_readdata <= 16'($urandom);
  end

  typedef struct {
    logic [15:0] data;
    logic        last;
  } word_t;

  typedef struct {
    logic [12:0] addr;
    logic [13:0] wc;
    int          mode;   // 0: ready high, 1: fixed pattern, 2: random
    int          exp_n;  // expected number of buffer reads
  } vec_t;

  word_t       exp_q[$];
  logic [12:0] exp_addr_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cs_run, acc_run, done_cnt;
  logic        prev_stall;
  logic [15:0] prev_data;
  logic        prev_last;

  function automatic logic [15:0] model_word(int a);
    logic [15:0] w;
    w = mem[a % NWORDS];
`ifdef PAYLOAD_READER_BYTESWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic load_expect(input int a, input int wc);
    int n;
    word_t w;
    n = (wc > NWORDS) ? NWORDS : wc;
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < n; i++) begin
      w.data = model_word(a + i);
      w.last = (i == n - 1);
      exp_q.push_back(w);
      exp_addr_q.push_back(13'((a + i) % NWORDS));
    end
    cs_run     = 0;
    acc_run    = 0;
    prev_stall = 1'b0;
  endtask

  // Sampled mid-cycle, away from the active edge.
  task automatic monitor();
    word_t       w;
    logic [12:0] a;
    if (prev_stall) begin
      chk("stall_stable", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
    end
    if (m_chipselect) begin
      cs_run++;
      if (exp_addr_q.size() == 0) begin
        chk("spurious_read", 32'(exp_addr_q.size()), 1);
      end else begin
        a = exp_addr_q.pop_front();
        chk("read_addr", m_address, a);
      end
      if (cs_run - acc_run > DEPTH) chk("outstanding", 32'(cs_run - acc_run), DEPTH);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_word", 32'(exp_q.size()), 1);
      end else begin
        w = exp_q.pop_front();
        chk("word", {out_last, out_data}, {w.last, w.data});
      end
      acc_run++;
    end
    if (done) begin
      done_cnt++;
      chk("busy_at_done", busy, 0);
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cs"}, m_chipselect, 0);
    chk({tag, "_addr"}, m_address, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_write"}, m_write, 0);
    chk({tag, "_be"}, m_byteenable, 2'b11);
    chk({tag, "_clken"}, m_clken, 1);
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    logic [7:0] pat;
    pat = 8'b1110_1001;  // 1,0,0,1,0,1,1,1 from bit 0 upward
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[cyc % 8];
    return 1'($urandom % 2);
  endfunction

  task automatic run_job(input string name, input int a, input int wc,
                         input int exp_n, input int mode);
    int d0;
    int budget;
    load_expect(a, wc);
    d0         = done_cnt;
    budget     = exp_n * 4 + 50;
    start_addr = 13'(a);
    word_count = 14'(wc);
    start      = 1'b1;
    out_ready  = ready_for(mode, 0);
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < budget && done_cnt == d0; cyc++) begin
      out_ready = ready_for(mode, cyc);
      if (mode == 2) begin
        // Stray starts while busy must be ignored.
        start      = ($urandom % 8) == 0;
        start_addr = 13'($urandom);
        word_count = 14'($urandom_range(1, 50));
      end
      tick();
    end
    start = 1'b0;
    chk({name, "_done_seen"}, 32'(done_cnt - d0), 1);
    chk({name, "_reads"}, 32'(cs_run), 32'(exp_n));
    chk({name, "_words_left"}, 32'(exp_q.size()), 0);
    chk({name, "_done_width"}, done, 0);
    $display("run %s addr=%04h count=%0d mode=%0d reads=%0d words=%0d", name, a, wc, mode,
             cs_run, acc_run);
  endtask

  vec_t tbl[6];

  initial begin
    int d0;
    int wc;

    for (int i = 0; i < NWORDS; i++) mem[i] = 16'(16'hA000 + i);

    tbl[0] = '{13'h1FFE, 14'd4,     0, 4};
    tbl[1] = '{13'h0100, 14'd8,     1, 8};
    tbl[2] = '{13'h0200, 14'd0,     0, 0};
    tbl[3] = '{13'h0040, 14'd3,     2, 3};
    tbl[4] = '{13'h0000, 14'h3FFF,  0, 8192};
    tbl[5] = '{13'h1FF0, 14'd8193,  2, 8192};

    done_cnt   = 0;
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    out_ready  = 1'b0;
    load_expect(0, 0);
    tick();
    tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Basic run with exact cycle timing.
    load_expect(16'h10, 5);
    d0         = done_cnt;
    start_addr = 13'h010;
    word_count = 14'd5;
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk("lat_busy", busy, 1);
    chk("lat_cs", m_chipselect, 1);
    chk("lat_addr", m_address, 13'h010);
    tick();
    chk("lat_valid_early", out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("lat_valid", out_valid, 1);
      chk("lat_data", out_data, model_word(16 + i));
      chk("lat_last", out_last, (i == 4));
    end
    tick();
    chk("lat_done", done, 1);
    chk("lat_busy_low", busy, 0);
    chk("lat_valid_end", out_valid, 0);
    tick();
    chk("lat_done_width", done, 0);
    chk("lat_reads", 32'(cs_run), 5);
    chk("lat_done_count", 32'(done_cnt - d0), 1);
    $display("run basic addr=0010 count=5 reads=%0d words=%0d", cs_run, acc_run);

    // Table-driven runs.
    for (int i = 0; i < 6; i++) begin
      run_job($sformatf("tbl%0d", i), int'(tbl[i].addr), int'(tbl[i].wc), tbl[i].exp_n,
              tbl[i].mode);
    end

    // Randomized runs.
    for (int i = 0; i < 6; i++) begin
      wc = $urandom_range(0, 40);
      run_job($sformatf("rnd%0d", i), $urandom_range(0, NWORDS - 1), wc, wc, 2);
    end

    // Reset in the middle of a long run.
    load_expect(0, 100);
    d0         = done_cnt;
    start_addr = '0;
    word_count = 14'd100;
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && acc_run < 20; cyc++) tick();
    chk("midrun_accepted", 32'(acc_run), 20);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrun");
    exp_q.delete();
    exp_addr_q.delete();
    tick();
    tick();
    chk("midrun_no_done", 32'(done_cnt - d0), 0);
    reset = 1'b0;
    tick();
    run_job("after_reset", 0, 2, 2, 0);

    // Single word with a distinctive pattern (byte order visible if swapped).
    mem[0] = 16'h1234;
    run_job("single", 0, 1, 1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
